// File: rtl/npu_param_loader.sv
// Writer side of the NPU parameter/input interface: deserializes a word-serial
// valid/ready stream into the registered weight, bias and input-vector buses.
module npu_param_loader #(
  parameter int unsigned IN_N       = 4,
  parameter int unsigned HIDDEN_N   = 4,
  parameter int unsigned OUT_N      = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   cmd_valid,
  input  logic                                   cmd_vec_only,
  output logic                                   cmd_ready,
  input  logic                                   s_valid,
  input  logic [DATA_WIDTH-1:0]                  s_data,
  input  logic                                   s_last,
  output logic                                   s_ready,
  output logic [HIDDEN_N*IN_N*DATA_WIDTH-1:0]    weights1,
  output logic [HIDDEN_N*DATA_WIDTH-1:0]         biases1,
  output logic [OUT_N*HIDDEN_N*DATA_WIDTH-1:0]   weights2,
  output logic [OUT_N*DATA_WIDTH-1:0]            biases2,
  output logic [IN_N*DATA_WIDTH-1:0]             in_vec,
  output logic                                   params_valid,
  output logic                                   done,
  output logic                                   err
);

  localparam int unsigned W1_N  = HIDDEN_N * IN_N;
  localparam int unsigned B1_N  = HIDDEN_N;
  localparam int unsigned W2_N  = OUT_N * HIDDEN_N;
  localparam int unsigned B2_N  = OUT_N;
  localparam int unsigned VEC_N = IN_N;

  localparam int unsigned MAX_A = (W1_N > W2_N) ? W1_N : W2_N;
  localparam int unsigned MAX_B = (B1_N > B2_N) ? B1_N : B2_N;
  localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_N = (MAX_C > VEC_N) ? MAX_C : VEC_N;
  localparam int unsigned CNT_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    W1   = 3'd1,
    B1   = 3'd2,
    W2   = 3'd3,
    B2   = 3'd4,
    VEC  = 3'd5
  } state_e;

  state_e                              state_q, state_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic [W1_N*DATA_WIDTH-1:0]          w1_q, w1_d;
  logic [B1_N*DATA_WIDTH-1:0]          b1_q, b1_d;
  logic [W2_N*DATA_WIDTH-1:0]          w2_q, w2_d;
  logic [B2_N*DATA_WIDTH-1:0]          b2_q, b2_d;
  logic [VEC_N*DATA_WIDTH-1:0]         vec_q, vec_d;
  logic                                params_valid_q, params_valid_d;
  logic                                done_q, done_d;
  logic                                err_q, err_d;
  logic                                cmd_ready_q, cmd_ready_d;
  logic                                s_ready_q, s_ready_d;

  logic                                beat;
  logic                                last_word;
  logic                                final_word;
  logic [CNT_W-1:0]                    sec_last;
  state_e                              next_sec;

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      w1_q           <= '0;
      b1_q           <= '0;
      w2_q           <= '0;
      b2_q           <= '0;
      vec_q          <= '0;
      params_valid_q <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      cmd_ready_q    <= 1'b0;
      s_ready_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      w1_q           <= w1_d;
      b1_q           <= b1_d;
      w2_q           <= w2_d;
      b2_q           <= b2_d;
      vec_q          <= vec_d;
      params_valid_q <= params_valid_d;
      done_q         <= done_d;
      err_q          <= err_d;
      cmd_ready_q    <= cmd_ready_d;
      s_ready_q      <= s_ready_d;
    end
  end

  // Next-state, word placement and completion/framing decisions.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    w1_d           = w1_q;
    b1_d           = b1_q;
    w2_d           = w2_q;
    b2_d           = b2_q;
    vec_d          = vec_q;
    params_valid_d = params_valid_q;
    done_d         = 1'b0;
    err_d          = err_q;
    sec_last       = '0;
    next_sec       = IDLE;
    last_word      = 1'b0;
    final_word     = 1'b0;
    beat           = s_valid && s_ready_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          params_valid_d = 1'b0;
          err_d          = 1'b0;
          cnt_d          = '0;
          state_d        = cmd_vec_only ? VEC : W1;
        end
      end
      W1: begin
        sec_last = CNT_W'(W1_N - 1);
        next_sec = B1;
        for (int k = 0; k < W1_N; k++)
          if (beat && cnt_q == CNT_W'(k)) w1_d[k*DATA_WIDTH +: DATA_WIDTH] = s_data;
      end
      B1: begin
        sec_last = CNT_W'(B1_N - 1);
        next_sec = W2;
        for (int k = 0; k < B1_N; k++)
          if (beat && cnt_q == CNT_W'(k)) b1_d[k*DATA_WIDTH +: DATA_WIDTH] = s_data;
      end
      W2: begin
        sec_last = CNT_W'(W2_N - 1);
        next_sec = B2;
        for (int k = 0; k < W2_N; k++)
          if (beat && cnt_q == CNT_W'(k)) w2_d[k*DATA_WIDTH +: DATA_WIDTH] = s_data;
      end
      B2: begin
        sec_last = CNT_W'(B2_N - 1);
        next_sec = VEC;
        for (int k = 0; k < B2_N; k++)
          if (beat && cnt_q == CNT_W'(k)) b2_d[k*DATA_WIDTH +: DATA_WIDTH] = s_data;
      end
      VEC: begin
        sec_last = CNT_W'(VEC_N - 1);
        next_sec = IDLE;
        for (int k = 0; k < VEC_N; k++)
          if (beat && cnt_q == CNT_W'(k)) vec_d[k*DATA_WIDTH +: DATA_WIDTH] = s_data;
      end
      default: state_d = IDLE;
    endcase

    // s_last must coincide exactly with the final VEC word; anything else aborts.
    if (state_q != IDLE && beat) begin
      last_word  = (cnt_q == sec_last);
      final_word = (state_q == VEC) && last_word;
      if (s_last != final_word) begin
        err_d   = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end else if (final_word) begin
        params_valid_d = 1'b1;
        done_d         = 1'b1;
        state_d        = IDLE;
        cnt_d          = '0;
      end else if (last_word) begin
        cnt_d   = '0;
        state_d = next_sec;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    cmd_ready_d = (state_d == IDLE);
    s_ready_d   = (state_d != IDLE);
  end

  assign cmd_ready    = cmd_ready_q;
  assign s_ready      = s_ready_q;
  assign weights1     = w1_q;
  assign biases1      = b1_q;
  assign weights2     = w2_q;
  assign biases2      = b2_q;
  assign in_vec       = vec_q;
  assign params_valid = params_valid_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_npu_param_loader.sv
// Bench for npu_param_loader: table of load transactions with a scoreboard
// queue checked on each done/err event, plus reset and mid-load sequences.
module tb_npu_param_loader;

  localparam int unsigned IN_N = 2, HIDDEN_N = 2, OUT_N = 2, DW = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_vec_only = 1'b0, cmd_ready;
  logic        s_valid = 1'b0, s_last = 1'b0, s_ready;
  logic [7:0]  s_data = 8'h00;
  logic [31:0] weights1, weights2;
  logic [15:0] biases1, biases2, in_vec;
  logic        params_valid, done, err;

  always #5 clk = ~clk;

  npu_param_loader #(.IN_N(IN_N), .HIDDEN_N(HIDDEN_N), .OUT_N(OUT_N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_vec_only(cmd_vec_only), .cmd_ready(cmd_ready),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .weights1(weights1), .biases1(biases1), .weights2(weights2), .biases2(biases2),
    .in_vec(in_vec), .params_valid(params_valid), .done(done), .err(err)
  );

  typedef struct {
    bit          vec_only;
    int          n;
    int          last_idx;
    logic [7:0]  base;
    bit          stall;
    logic [31:0] w1;
    logic [15:0] b1;
    logic [31:0] w2;
    logic [15:0] b2;
    logic [15:0] vec;
    bit          ok;
  } rec_t;

  rec_t recs[6];
  rec_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: each done pulse or rising err retires the oldest expected record.
  logic err_prev = 1'b0;
  rec_t e;
  always @(negedge clk) begin
    if (!rst_n) begin
      err_prev = 1'b0;
    end else begin
      if (done || (err && !err_prev)) begin
        if (sb.size() == 0) begin
          chk("unexpected_event", {30'd0, err, done}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("end_done", 32'(done), 32'(e.ok));
          chk("end_err", 32'(err), 32'(!e.ok));
          chk("end_params_valid", 32'(params_valid), 32'(e.ok));
          chk("end_cmd_ready", 32'(cmd_ready), 32'd1);
          chk("weights1", weights1, e.w1);
          chk("biases1", 32'(biases1), 32'(e.b1));
          chk("weights2", weights2, e.w2);
          chk("biases2", 32'(biases2), 32'(e.b2));
          chk("in_vec", 32'(in_vec), 32'(e.vec));
        end
      end
      err_prev = err;
    end
  end

  task automatic run_rec(input rec_t r);
    int t;
    sb.push_back(r);
    cmd_vec_only = r.vec_only;
    cmd_valid    = 1'b1;
    t = 0;
    while (!cmd_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    if (!r.stall) cmd_valid = 1'b0;
    chk("accept_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("accept_s_ready", 32'(s_ready), 32'd1);
    chk("accept_params_valid", 32'(params_valid), 32'd0);
    chk("accept_err", 32'(err), 32'd0);
    for (int i = 0; i < r.n; i++) begin
      if (r.stall) begin
        s_valid = 1'b0;
        s_data  = 8'hEE;
        s_last  = 1'b1;
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = 8'(r.base + 8'(i));
      s_last  = (i == r.last_idx);
      chk("load_params_valid", 32'(params_valid), 32'd0);
      if (r.stall) chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb.size() != 0) begin
      chk("end_event_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    recs[0] = '{1'b0, 14, 13, 8'h01, 1'b0, 32'h04030201, 16'h0605, 32'h0A090807, 16'h0C0B, 16'h0E0D, 1'b1};
    recs[1] = '{1'b1, 2, 1, 8'h7F, 1'b0, 32'h04030201, 16'h0605, 32'h0A090807, 16'h0C0B, 16'h807F, 1'b1};
    recs[2] = '{1'b0, 3, 2, 8'h21, 1'b0, 32'h04232221, 16'h0605, 32'h0A090807, 16'h0C0B, 16'h807F, 1'b0};
    recs[3] = '{1'b0, 14, -1, 8'h31, 1'b0, 32'h34333231, 16'h3635, 32'h3A393837, 16'h3C3B, 16'h3E3D, 1'b0};
    recs[4] = '{1'b1, 1, 0, 8'h50, 1'b0, 32'h34333231, 16'h3635, 32'h3A393837, 16'h3C3B, 16'h3E50, 1'b0};
    recs[5] = '{1'b0, 14, 13, 8'h01, 1'b1, 32'h04030201, 16'h0605, 32'h0A090807, 16'h0C0B, 16'h0E0D, 1'b1};

    // Reset values
    #12;
    chk("rst_weights1", weights1, 32'd0);
    chk("rst_biases1", 32'(biases1), 32'd0);
    chk("rst_weights2", weights2, 32'd0);
    chk("rst_biases2", 32'(biases2), 32'd0);
    chk("rst_in_vec", 32'(in_vec), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_flags", {29'd0, params_valid, done, err}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_s_ready", 32'(s_ready), 32'd0);

    // Stream words while idle must be ignored
    s_valid = 1'b1;
    s_data  = 8'hAA;
    s_last  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("idle_weights1", weights1, 32'd0);
    chk("idle_in_vec", 32'(in_vec), 32'd0);
    chk("idle_flags", {29'd0, params_valid, done, err}, 32'd0);
    chk("idle_s_ready", 32'(s_ready), 32'd0);

    for (int i = 0; i < 6; i++) run_rec(recs[i]);

    // Held cmd_valid is taken one cycle after the stalled load returns to IDLE
    chk("reaccept_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("reaccept_s_ready", 32'(s_ready), 32'd1);
    chk("reaccept_params_valid", 32'(params_valid), 32'd0);
    cmd_valid = 1'b0;

    // Reset in the middle of a load
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(8'h41 + 8'(i));
      s_last  = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    chk("midload_weights1", weights1, 32'h44434241);
    chk("midload_biases1", 32'(biases1), 32'h0645);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_weights1", weights1, 32'd0);
    chk("midrst_biases1", 32'(biases1), 32'd0);
    chk("midrst_weights2", weights2, 32'd0);
    chk("midrst_biases2", 32'(biases2), 32'd0);
    chk("midrst_in_vec", 32'(in_vec), 32'd0);
    chk("midrst_flags", {29'd0, params_valid, done, err}, 32'd0);
    chk("midrst_s_ready", 32'(s_ready), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_idle_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("midrst_idle_s_ready", 32'(s_ready), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/npu_param_loader.md
Name: npu_param_loader

Overview:
- Writer side of the kiwiNPU parameter/input interface.
- Accepts a word-serial valid/ready stream and deserializes it into the registered packed buses the NPU consumes: weights1, biases1, weights2, biases2, in_vec.
- A command selects either a full parameter load or an input-vector-only reload.
- It flags completion and framing errors so the upstream host/DMA knows when the NPU buses are coherent.

Parameters:
- IN_N, `N, input vector length.
- HIDDEN_N, `M, hidden layer length.
- OUT_N, `N, output vector length.
- DATA_WIDTH, `DATA_WIDTH, bits per word; signed two's complement.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous reset, active low.
- cmd_valid  input  1  load command present.
- cmd_vec_only  input  1  1 = reload in_vec only; 0 = full load. Sampled on cmd accept.
- cmd_ready  output  1  loader idle, can accept a command.
- s_valid  input  1  stream word valid.
- s_data  input  DATA_WIDTH  stream word.
- s_last  input  1  marks the final word of the load.
- s_ready  output  1  loader accepts a stream word this cycle.
- weights1  output  HIDDEN_N*IN_N*DATA_WIDTH  packed layer-1 weights.
- biases1  output  HIDDEN_N*DATA_WIDTH  packed layer-1 biases.
- weights2  output  OUT_N*HIDDEN_N*DATA_WIDTH  packed layer-2 weights.
- biases2  output  OUT_N*DATA_WIDTH  packed layer-2 biases.
- in_vec  output  IN_N*DATA_WIDTH  packed input vector.
- params_valid  output  1  all buses coherent; level signal.
- done  output  1  one-cycle pulse on load completion.
- err  output  1  sticky framing error.

Behaviour:
- Clock and reset: single clock domain clk. rst_n is asynchronous, active low.
- Reset values: state IDLE; all packed buses 0; params_valid=0, done=0, err=0; word counter 0.
- States: IDLE, W1, B1, W2, B2, VEC.
- IDLE:
  - cmd_ready=1, s_ready=0.
  - On cmd_valid&&cmd_ready: clear params_valid and err; counter=0; next state is VEC if cmd_vec_only, else W1.
- Load states (W1..VEC):
  - cmd_ready=0, s_ready=1.
  - A beat transfers when s_valid&&s_ready.
  - Word k (0-based within the section) writes bits [k*DATA_WIDTH +: DATA_WIDTH] of that section's bus on the same clock edge. Other bits are held.
- Section sizes:
  - W1 = HIDDEN_N*IN_N
  - B1 = HIDDEN_N
  - W2 = OUT_N*HIDDEN_N
  - B2 = OUT_N
  - VEC = IN_N
- Section advance: on the last word of a section, counter resets to 0 and the state advances W1->B1->W2->B2->VEC. The counter is sized $clog2 of the largest section, minimum 1 bit.
- Completion: the beat is the last word of VEC with s_last=1. On that edge: state->IDLE, params_valid<=1, done<=1 for exactly one cycle. No extra latency; the new buses are visible the cycle done is high.
- Framing errors:
  - Case 1: s_last=1 on any beat other than the final VEC word.
  - Case 2: s_last=0 on the final VEC word.
  - Either case: that word is still written, err<=1, state->IDLE, params_valid stays 0, done not asserted.
- err is sticky; it clears only on the next accepted command or on reset.
- s_valid in IDLE is ignored; no buses change.
- cmd_valid during a load is held off (cmd_ready=0) and is not queued.
- s_valid low stalls the load indefinitely with no state change.
- Vector-only reload leaves weights/biases untouched. params_valid still drops for the reload duration.
- Asserting rst_n low mid-load returns everything to reset values immediately, buses included.

Test Plan:
Override IN_N=2, HIDDEN_N=2, OUT_N=2, DATA_WIDTH=8.
- Reset: assert rst_n=0 -> all buses 0, cmd_ready=0 during reset then 1 after release, params_valid=0, done=0, err=0.
- Full load: cmd (vec_only=0), stream 0x01..0x0E with s_last on 0x0E ->
  - weights1=0x04030201, biases1=0x0605, weights2=0x0A090807, biases2=0x0C0B, in_vec=0x0E0D;
  - done pulses one cycle; params_valid=1.
- Vec-only reload after the full load: stream 0x7F, 0x80(last) ->
  - in_vec=0x807F; weights/biases unchanged;
  - params_valid low between cmd accept and done.
- Backpressure/stall: full load with s_valid toggled every other cycle, and an extra cmd_valid held throughout ->
  - same final values as the full-load test;
  - cmd_ready=0 until done;
  - second cmd accepted the cycle after return to IDLE.
- Framing errors:
  - s_last on the 3rd word -> err=1, IDLE, params_valid=0, no done.
  - Final word without s_last -> err=1.
  - Next cmd accept clears err.
- Reset mid-load: drop rst_n after 5 words -> all buses 0, state IDLE, params_valid=0.
